// File: rtl/load_align_unit_pkg.sv
// Shared load-unit definitions: RV32 load funct3 encodings,
// FSM state encoding and small decode helpers.
package load_align_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RSP
    } state_t;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) ||
               ((f3 == F3_LW) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select and sign/zero extension of a little-endian
// read word for RV32 loads (combinational).
module load_extend
    import load_align_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        unique case (addr_lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   result = {{24{b[7]}}, b};
            F3_LH:   result = {{16{h[15]}}, h};
            F3_LW:   result = rdata;
            F3_LBU:  result = {24'b0, b};
            F3_LHU:  result = {16'b0, h};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Multi-cycle RV32 load unit: IDLE->REQ->WAIT->RSP.
// Define MISALIGN_TRAP_EN to trap misaligned LH/LHU/LW.
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam bit TMO_EN = (TIMEOUT_CYC != 0);

    state_t        state_q, state_d;
    logic [1:0]    lo_q, lo_d;
    logic [2:0]    f3_q, f3_d;
    logic          mem_req_d;
    logic [31:0]   mem_addr_d;
    logic          rsp_valid_d;
    logic [31:0]   rsp_data_d;
    logic          rsp_err_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   ext;
    logic          trap;

`ifdef MISALIGN_TRAP_EN
    assign trap = misaligned(req_funct3, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign req_ready = (state_q == S_IDLE);

    load_extend u_ext (
        .rdata   (mem_rdata),
        .addr_lo (lo_q),
        .funct3  (f3_q),
        .result  (ext)
    );

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        f3_d        = f3_q;
        mem_req_d   = mem_req;
        mem_addr_d  = mem_addr;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        timer_d     = timer_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    lo_d = req_addr[1:0];
                    f3_d = req_funct3;
                    if (f3_illegal(req_funct3) || trap) begin
                        state_d     = S_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d    = S_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {req_addr[31:2], 2'b00};
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d   = S_WAIT;
                    mem_req_d = 1'b0;
                    timer_d   = '0;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = ext;
                end else if (TMO_EN && timer_q == TMO_LAST) begin
                    state_d     = S_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lo_q      <= '0;
            f3_q      <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            f3_q      <= f3_d;
            mem_req   <= mem_req_d;
            mem_addr  <= mem_addr_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            timer_q   <= timer_d;
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit (TIMEOUT_CYC=4).
// Honours MISALIGN_TRAP_EN for the misaligned LW case.
module tb_load_align_unit;
    import load_align_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    always #5 clk = ~clk;

    load_align_unit #(.TIMEOUT_CYC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("stray_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] rd,
                                          input logic [1:0] lo,
                                          input logic [2:0] f3);
        logic [31:0] s;
        case (f3)
            F3_LB: begin
                s = rd >> (8 * lo);
                return {{24{s[7]}}, s[7:0]};
            end
            F3_LBU: begin
                s = rd >> (8 * lo);
                return {24'b0, s[7:0]};
            end
            F3_LH: begin
                s = rd >> (16 * lo[1]);
                return {{16{s[15]}}, s[15:0]};
            end
            F3_LHU: begin
                s = rd >> (16 * lo[1]);
                return {16'b0, s[15:0]};
            end
            F3_LW:   return rd;
            default: return 32'd0;
        endcase
    endfunction

    // One load: mem selects whether a memory access is expected.
    task automatic load(input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] rd, input bit mem,
                        input int gdly, input int rdly, input int hold,
                        input bit err, input logic [31:0] exp);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_addr   = a;
        req_funct3 = f3;
        req_valid  = 1'b1;
        sb.push_back({err, exp});
        step(1);
        req_valid = 1'b0;
        if (mem) begin
            check("mem_req_on", {31'b0, mem_req}, 32'd1);
            check("mem_addr", mem_addr, {a[31:2], 2'b00});
            check("req_ready_busy", {31'b0, req_ready}, 32'd0);
            repeat (gdly) begin
                mem_rvalid = 1'b1;
                mem_rdata  = ~rd;
                step(1);
                check("mem_req_hold", {31'b0, mem_req}, 32'd1);
            end
            mem_rvalid = 1'b0;
            mem_gnt    = 1'b1;
            step(1);
            mem_gnt = 1'b0;
            check("mem_req_off", {31'b0, mem_req}, 32'd0);
            repeat (rdly) step(1);
            check("no_early_rsp", {31'b0, rsp_valid}, 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            step(1);
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hx;
        end else begin
            check("no_mem_req", {31'b0, mem_req}, 32'd0);
        end
        check("rsp_valid_up", {31'b0, rsp_valid}, 32'd1);
        repeat (hold) begin
            step(1);
            check("rsp_hold_v", {31'b0, rsp_valid}, 32'd1);
            check("rsp_hold_d", rsp_data, exp);
        end
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        check("rsp_valid_dn", {31'b0, rsp_valid}, 32'd0);
    endtask

    logic [2:0]  f3s [5];
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rrd;

    initial begin
        f3s = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_funct3 = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        rsp_ready  = 1'b0;
        step(2);
        rst = 1'b0;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);

        load(32'h1003, F3_LB, 32'h80FF_1234, 1, 0, 0, 0, 0, 32'hFFFF_FF80);
        load(32'h1002, F3_LHU, 32'h8001_0000, 1, 1, 1, 0, 0, 32'h0000_8001);
        load(32'h1002, F3_LH, 32'h8001_0000, 1, 0, 2, 1, 0, 32'hFFFF_8001);
`ifdef MISALIGN_TRAP_EN
        load(32'h1002, F3_LW, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 32'd0);
`else
        load(32'h1002, F3_LW, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 32'hDEAD_BEEF);
`endif
        load(32'h2000, 3'b011, 32'h0, 0, 0, 0, 5, 1, 32'd0);
        load(32'h2000, 3'b110, 32'h0, 0, 0, 0, 0, 1, 32'd0);

        // watchdog: grant but never return data
        check("tmo_ready", {31'b0, req_ready}, 32'd1);
        req_addr   = 32'h3000;
        req_funct3 = F3_LW;
        req_valid  = 1'b1;
        sb.push_back({1'b1, 32'd0});
        step(1);
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        step(1);
        mem_gnt = 1'b0;
        step(3);
        check("tmo_not_yet", {31'b0, rsp_valid}, 32'd0);
        step(1);
        check("tmo_fire", {31'b0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        step(1);
        rsp_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        step(1);
        mem_rvalid = 1'b0;
        check("late_rv_ignored", {31'b0, rsp_valid}, 32'd0);
        check("late_rv_ready", {31'b0, req_ready}, 32'd1);

        // reset while waiting for data
        req_addr   = 32'h4000;
        req_funct3 = F3_LW;
        req_valid  = 1'b1;
        step(1);
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        step(1);
        mem_gnt = 1'b0;
        rst     = 1'b1;
        step(1);
        rst = 1'b0;
        check("abort_mem_req", {31'b0, mem_req}, 32'd0);
        check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        rsp_ready  = 1'b1;
        step(2);
        mem_rvalid = 1'b0;
        rsp_ready  = 1'b0;
        check("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            rf3 = f3s[$urandom_range(0, 4)];
            ra  = $urandom;
            if (rf3 == F3_LW) ra[1:0] = 2'b00;
            if (rf3[1:0] == 2'b01) ra[0] = 1'b0;
            rrd = $urandom;
            load(ra, rf3, rrd, 1, $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2),
                 0, model(rrd, ra[1:0], rf3));
        end

        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
